// File: rtl/telemetry_link_supervisor.sv
// Telemetry receive-path supervisor: MMCM reset/lock sequencing, GT realign,
// frame-stream qualification, link up/down decision and bounded retry with fault latch.
module telemetry_link_supervisor #(
  parameter logic [15:0] G_RST_PULSE    = 16'd64,
  parameter logic [19:0] G_LOCK_WAIT    = 20'hfffff,
  parameter logic [15:0] G_GOOD_CNT     = 16'd1024,
  parameter logic [7:0]  G_ERR_LIMIT    = 8'd4,
  parameter logic [15:0] G_SYNC_TIMEOUT = 16'hffff,
  parameter logic [7:0]  G_MAX_RETRY    = 8'd16
) (
  input  logic        clk_128M,
  input  logic        rst_128M_n,
  input  logic        pll_locked_in,
  input  logic        frame_toggle_in,
  input  logic        frame_ok_in,
  input  logic        clear_fault_in,
  output logic        mmcm_rst_out,
  output logic        gt_realign_out,
  output logic        link_up_out,
  output logic        fault_out,
  output logic [2:0]  state_out,
  output logic [7:0]  retry_cnt_out,
  output logic [15:0] err_cnt_out
);

  // state     | meaning
  // IDLE      | one cycle after reset release
  // RESET_PLL | MMCM held in reset for G_RST_PULSE cycles
  // WAIT_LOCK | waiting for synchronized MMCM lock
  // ACQUIRE   | GT realigned, counting consecutive good frames
  // LINKED    | link up, watching bad-frame run and idle timer
  // FAULT     | retry budget exhausted, waits for clear_fault_in
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RESET_PLL = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_ACQUIRE   = 3'd3;
  localparam logic [2:0] S_LINKED    = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic lock_s1_q, lock_s2_q, tog_s1_q, tog_s2_q, tog_prev_q, ok_s1_q, ok_s2_q;
  logic frame_evt, frame_ok;

  logic [2:0]  state_q, state_d;
  logic [19:0] tmr_q, tmr_d;
  logic [15:0] good_q, good_d;
  logic [7:0]  bad_q, bad_d;
  logic [15:0] err_q, err_d;
  logic [7:0]  retry_q, retry_d;
  logic        mmcm_rst_q, mmcm_rst_d;
  logic        realign_q, realign_d;
  logic        link_up_q, link_up_d;
  logic        fault_q, fault_d;
  logic        retry_evt, enter;
  logic [2:0]  retry_tgt;

  always_ff @(posedge clk_128M or negedge rst_128M_n) begin
    if (!rst_128M_n) begin
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
      tog_s1_q   <= 1'b0;
      tog_s2_q   <= 1'b0;
      tog_prev_q <= 1'b0;
      ok_s1_q    <= 1'b0;
      ok_s2_q    <= 1'b0;
    end else begin
      lock_s1_q  <= pll_locked_in;
      lock_s2_q  <= lock_s1_q;
      tog_s1_q   <= frame_toggle_in;
      tog_s2_q   <= tog_s1_q;
      tog_prev_q <= tog_s2_q;
      ok_s1_q    <= frame_ok_in;
      ok_s2_q    <= ok_s1_q;
    end
  end

  assign frame_evt = tog_s2_q ^ tog_prev_q;
  assign frame_ok  = ok_s2_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_d     = err_q;
    retry_d   = retry_q;
    retry_evt = 1'b0;
    retry_tgt = state_q;
    enter     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_RESET_PLL;
        enter   = 1'b1;
      end
      S_RESET_PLL: begin
        if (tmr_q == 20'd0) begin
          state_d = S_WAIT_LOCK;
          enter   = 1'b1;
        end else begin
          tmr_d = tmr_q - 20'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s2_q) begin
          state_d = S_ACQUIRE;
          enter   = 1'b1;
        end else if (tmr_q == 20'd0) begin
          retry_evt = 1'b1;
          retry_tgt = S_RESET_PLL;
        end else begin
          tmr_d = tmr_q - 20'd1;
        end
      end
      S_ACQUIRE: begin
        // lock loss outranks frame and timeout events
        if (!lock_s2_q) begin
          retry_evt = 1'b1;
          retry_tgt = S_RESET_PLL;
        end else if (frame_evt) begin
          tmr_d = {4'd0, G_SYNC_TIMEOUT - 16'd1};
          if (!frame_ok) begin
            good_d = 16'd0;
          end else if (good_q + 16'd1 == G_GOOD_CNT) begin
            state_d = S_LINKED;
            enter   = 1'b1;
          end else begin
            good_d = good_q + 16'd1;
          end
        end else if (tmr_q == 20'd0) begin
          retry_evt = 1'b1;
          retry_tgt = S_ACQUIRE;
        end else begin
          tmr_d = tmr_q - 20'd1;
        end
      end
      S_LINKED: begin
        if (!lock_s2_q) begin
          retry_evt = 1'b1;
          retry_tgt = S_RESET_PLL;
        end else if (frame_evt) begin
          tmr_d = {4'd0, G_SYNC_TIMEOUT - 16'd1};
          if (frame_ok) begin
            bad_d = 8'd0;
          end else begin
            if (err_q != 16'hffff) err_d = err_q + 16'd1;
            if (bad_q + 8'd1 == G_ERR_LIMIT) begin
              retry_evt = 1'b1;
              retry_tgt = S_ACQUIRE;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end
        end else if (tmr_q == 20'd0) begin
          retry_evt = 1'b1;
          retry_tgt = S_ACQUIRE;
        end else begin
          tmr_d = tmr_q - 20'd1;
        end
      end
      S_FAULT: begin
        if (clear_fault_in) begin
          retry_d = 8'd0;
          state_d = S_RESET_PLL;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retry_evt) begin
      retry_d = (retry_q == 8'hff) ? 8'hff : retry_q + 8'd1;
      state_d = (retry_d > G_MAX_RETRY) ? S_FAULT : retry_tgt;
      enter   = 1'b1;
    end

    // every fresh occupancy reloads its timer and clears its run counters
    if (enter) begin
      case (state_d)
        S_RESET_PLL: tmr_d = {4'd0, G_RST_PULSE - 16'd1};
        S_WAIT_LOCK: tmr_d = G_LOCK_WAIT - 20'd1;
        S_ACQUIRE: begin
          tmr_d  = {4'd0, G_SYNC_TIMEOUT - 16'd1};
          good_d = 16'd0;
        end
        S_LINKED: begin
          tmr_d = {4'd0, G_SYNC_TIMEOUT - 16'd1};
          bad_d = 8'd0;
        end
        default: tmr_d = 20'd0;
      endcase
    end

    mmcm_rst_d = (state_d == S_RESET_PLL);
    realign_d  = enter && (state_d == S_ACQUIRE);
    link_up_d  = (state_d == S_LINKED);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge clk_128M or negedge rst_128M_n) begin
    if (!rst_128M_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= 20'd0;
      good_q     <= 16'd0;
      bad_q      <= 8'd0;
      err_q      <= 16'd0;
      retry_q    <= 8'd0;
      mmcm_rst_q <= 1'b0;
      realign_q  <= 1'b0;
      link_up_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= mmcm_rst_d;
      realign_q  <= realign_d;
      link_up_q  <= link_up_d;
      fault_q    <= fault_d;
    end
  end

  assign mmcm_rst_out   = mmcm_rst_q;
  assign gt_realign_out = realign_q;
  assign link_up_out    = link_up_q;
  assign fault_out      = fault_q;
  assign state_out      = state_q;
  assign retry_cnt_out  = retry_q;
  assign err_cnt_out    = err_q;

endmodule

// File: tb/tb_telemetry_link_supervisor.sv
// Directed bench for telemetry_link_supervisor with shortened timing parameters.
module tb_telemetry_link_supervisor;

  logic        clk_128M = 1'b0;
  logic        rst_128M_n = 1'b0;
  logic        pll_locked_in = 1'b0;
  logic        frame_toggle_in = 1'b0;
  logic        frame_ok_in = 1'b0;
  logic        clear_fault_in = 1'b0;
  logic        mmcm_rst_out;
  logic        gt_realign_out;
  logic        link_up_out;
  logic        fault_out;
  logic [2:0]  state_out;
  logic [7:0]  retry_cnt_out;
  logic [15:0] err_cnt_out;

  int n_checks = 0;
  int n_fail = 0;
  int realign_seen = 0;

  telemetry_link_supervisor #(
    .G_RST_PULSE(16'd4), .G_LOCK_WAIT(20'd20), .G_GOOD_CNT(16'd8),
    .G_ERR_LIMIT(8'd4), .G_SYNC_TIMEOUT(16'd50), .G_MAX_RETRY(8'd2)
  ) dut (
    .clk_128M(clk_128M), .rst_128M_n(rst_128M_n), .pll_locked_in(pll_locked_in),
    .frame_toggle_in(frame_toggle_in), .frame_ok_in(frame_ok_in),
    .clear_fault_in(clear_fault_in), .mmcm_rst_out(mmcm_rst_out),
    .gt_realign_out(gt_realign_out), .link_up_out(link_up_out), .fault_out(fault_out),
    .state_out(state_out), .retry_cnt_out(retry_cnt_out), .err_cnt_out(err_cnt_out)
  );

  always #5 clk_128M = ~clk_128M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_128M);
    #1;
    if (gt_realign_out) realign_seen++;
  endtask

  task automatic do_reset();
    rst_128M_n = 1'b0;
    pll_locked_in = 1'b0;
    frame_toggle_in = 1'b0;
    frame_ok_in = 1'b0;
    clear_fault_in = 1'b0;
    repeat (3) tick();
    rst_128M_n = 1'b1;
    realign_seen = 0;
  endtask

  task automatic send_frame(input logic ok);
    frame_ok_in = ok;
    frame_toggle_in = ~frame_toggle_in;
    repeat (6) tick();
  endtask

  // from fresh reset release: pulse, lock 10 cycles after pulse ends, 8 good frames
  task automatic bring_up();
    int hi;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mmcm_rst_out) hi++;
      else if (hi > 0) break;
    end
    check("rst_pulse_len", hi, 4);
    repeat (9) tick();
    pll_locked_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state_out == 3'd3) break;
    end
    check("acq_reached", state_out, 3);
    for (int f = 0; f < 7; f++) send_frame(1'b1);
    check("acq_after_7", state_out, 3);
    frame_ok_in = 1'b1;
    frame_toggle_in = ~frame_toggle_in;
    tick(); tick();
    check("link_before_8th", link_up_out, 0);
    tick();
    check("link_after_8th", link_up_out, 1);
    check("state_linked", state_out, 4);
    check("realign_once", realign_seen, 1);
    check("retry_zero", retry_cnt_out, 0);
    repeat (3) tick();
  endtask

  initial begin
    int rises;
    logic prev;

    // reset values
    #2;
    check("rst_state", state_out, 0);
    check("rst_outs", {mmcm_rst_out, gt_realign_out, link_up_out, fault_out}, 0);
    check("rst_cnts", {retry_cnt_out, err_cnt_out}, 0);

    // normal bring-up
    do_reset();
    check("idle_after_rel", state_out, 0);
    bring_up();

    // error drop: 3 bad, 1 ok, 3 bad stays linked; 4th consecutive bad drops
    realign_seen = 0;
    for (int f = 0; f < 3; f++) send_frame(1'b0);
    send_frame(1'b1);
    for (int f = 0; f < 3; f++) send_frame(1'b0);
    check("err_still_linked", state_out, 4);
    check("err_cnt_6", err_cnt_out, 6);
    frame_ok_in = 1'b0;
    frame_toggle_in = ~frame_toggle_in;
    tick(); tick();
    check("err_pre_drop", state_out, 4);
    tick();
    check("err_drop_state", state_out, 3);
    check("err_drop_realign", gt_realign_out, 1);
    check("err_cnt_7", err_cnt_out, 7);
    check("err_retry_1", retry_cnt_out, 1);

    // lock timeout into fault
    do_reset();
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (mmcm_rst_out && !prev) rises++;
      prev = mmcm_rst_out;
      if (fault_out) break;
    end
    check("lto_fault", fault_out, 1);
    check("lto_pulses", rises, 3);
    check("lto_retry", retry_cnt_out, 3);
    check("lto_state", state_out, 5);
    repeat (5) tick();
    check("lto_frozen", {state_out, retry_cnt_out, 4'(mmcm_rst_out)}, {3'd5, 8'd3, 4'd0});
    clear_fault_in = 1'b1;
    tick();
    clear_fault_in = 1'b0;
    check("clr_retry", retry_cnt_out, 0);
    check("clr_state", state_out, 1);
    check("clr_fault_low", fault_out, 0);

    // sync timeout: silence after last frame
    do_reset();
    bring_up();
    realign_seen = 0;
    frame_ok_in = 1'b1;
    frame_toggle_in = ~frame_toggle_in;
    repeat (52) tick();
    check("sto_still_linked", state_out, 4);
    tick();
    check("sto_acq", state_out, 3);
    check("sto_realign1", gt_realign_out, 1);
    check("sto_retry1", retry_cnt_out, 1);
    repeat (49) tick();
    check("sto_mid", {state_out, 1'(gt_realign_out)}, {3'd3, 1'b0});
    tick();
    check("sto_realign2", gt_realign_out, 1);
    check("sto_retry2", retry_cnt_out, 2);
    repeat (50) tick();
    check("sto_fault", state_out, 5);
    check("sto_realign_cnt", realign_seen, 2);

    // priority: lock drop coincides with the limit-hitting bad frame
    do_reset();
    bring_up();
    for (int f = 0; f < 3; f++) send_frame(1'b0);
    frame_ok_in = 1'b0;
    frame_toggle_in = ~frame_toggle_in;
    pll_locked_in = 1'b0;
    tick(); tick();
    check("pri_pre", state_out, 4);
    tick();
    check("pri_state", state_out, 1);
    check("pri_retry", retry_cnt_out, 1);
    check("pri_mmcm", mmcm_rst_out, 1);
    check("pri_realign", gt_realign_out, 0);

    // async reset mid-RESET_PLL
    do_reset();
    tick(); tick();
    check("ar1_pre", mmcm_rst_out, 1);
    #2 rst_128M_n = 1'b0;
    #1;
    check("ar1_mmcm", mmcm_rst_out, 0);
    check("ar1_state", state_out, 0);
    @(posedge clk_128M);
    #1 rst_128M_n = 1'b1;
    check("ar1_idle", state_out, 0);
    tick();
    check("ar1_resetpll", {state_out, 1'(mmcm_rst_out)}, {3'd1, 1'b1});

    // async reset mid-LINKED
    do_reset();
    bring_up();
    send_frame(1'b0);
    check("ar2_err", err_cnt_out, 1);
    #2 rst_128M_n = 1'b0;
    #1;
    check("ar2_outs", {link_up_out, 3'(state_out), 16'(err_cnt_out)}, 0);
    rst_128M_n = 1'b1;
    tick();
    check("ar2_resetpll", state_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/telemetry_link_supervisor.md
# telemetry_link_supervisor

Free-running controller that brings up and keeps up the telemetry receive path. It sequences the 128M→256M MMCM reset and lock wait, then commands GT comma realignment. It qualifies the unpacked frame stream, declares the link up or down, and retries with a bounded budget before latching a fault. It runs on clk_128M because clk_256M stops while the MMCM is in reset. Frame status crosses in from the clk_256M domain as a toggle/level pair.

## Interface
- G_RST_PULSE, 16'd64: clk_128M cycles mmcm_rst_out is held high per PLL reset.
- G_LOCK_WAIT, 20'hfffff: cycles to wait for synchronized lock before counting a retry.
- G_GOOD_CNT, 16'd1024: consecutive good frames required to declare link up.
- G_ERR_LIMIT, 8'd4: consecutive bad frames in LINKED that drop the link.
- G_SYNC_TIMEOUT, 16'hffff: cycles with no frame event before declaring loss (ACQUIRE and LINKED).
- G_MAX_RETRY, 8'd16: retries allowed before FAULT.

Ports:
- clk_128M  in  1  free-running reference clock
- rst_128M_n  in  1  asynchronous active-low reset
- pll_locked_in  in  1  MMCM locked, asynchronous; 2-flop synchronized internally
- frame_toggle_in  in  1  clk_256M domain; toggles once per unpacked frame
- frame_ok_in  in  1  clk_256M domain; match result, stable from toggle until next toggle
- clear_fault_in  in  1  synchronous; one-cycle pulse exits FAULT
- mmcm_rst_out  out  1  active-high MMCM reset
- gt_realign_out  out  1  one-cycle realign request to GT
- link_up_out  out  1  high only in LINKED
- fault_out  out  1  high only in FAULT
- state_out  out  3  IDLE=0, RESET_PLL=1, WAIT_LOCK=2, ACQUIRE=3, LINKED=4, FAULT=5
- retry_cnt_out  out  8  retries since reset or fault clear, saturating at 255
- err_cnt_out  out  16  total bad frames seen in LINKED, saturating at 16'hffff

## Operation
- CDC: pll_locked_in, frame_toggle_in and frame_ok_in each pass through 2 flops. A third toggle flop gives frame_evt = sync_toggle XOR prev. frame_ok is sampled on frame_evt. Frame spacing (~1.6 µs) guarantees ok is settled.
- IDLE: occupied one cycle after reset release, then goes to RESET_PLL.
- RESET_PLL: mmcm_rst_out=1 for exactly G_RST_PULSE cycles, then WAIT_LOCK.
- WAIT_LOCK: lock counter runs. Synced lock high goes to ACQUIRE. Counter reaching G_LOCK_WAIT goes to retry→RESET_PLL.
- ACQUIRE: gt_realign_out pulses on the entry cycle only. good_cnt and idle timer clear on entry.
  - frame_evt&ok: good_cnt++, timer clears; good_cnt reaching G_GOOD_CNT goes to LINKED.
  - frame_evt&!ok: good_cnt clears.
  - Timer reaching G_SYNC_TIMEOUT: retry→ACQUIRE (re-entry, new realign pulse).
- LINKED: link_up_out=1.
  - frame_evt&!ok: bad_cnt++, err_cnt++ (saturating).
  - frame_evt&ok: bad_cnt clears.
  - bad_cnt reaching G_ERR_LIMIT, or idle timer reaching G_SYNC_TIMEOUT: retry→ACQUIRE.
- Lock loss (synced lock low) in ACQUIRE or LINKED: retry→RESET_PLL. Lock loss has priority over frame and timeout events in the same cycle.
- retry: retry_cnt++ (saturating). If the post-increment value exceeds G_MAX_RETRY, go to FAULT instead of the target.
- FAULT: mmcm_rst_out=0, all counters frozen. clear_fault_in zeroes retry_cnt and goes to RESET_PLL. clear_fault_in is ignored in other states.
- Reset mid-operation: all state, counters and outputs return to reset values immediately (async); mmcm_rst_out drops to 0.

## Timing
- Reset values: state_out=0, all outputs 0, all counters 0.
- All outputs are registered and derived from the current state and counters; no combinational input→output path.
- frame_evt occurs 3 clk_128M cycles after the toggle edge arrives at the pin. pll_locked is seen 2 cycles after.
- Transition to LINKED occurs in the cycle after the G_GOOD_CNT-th good frame_evt. link_up_out rises in that same registered update.
- gt_realign_out is high in the first cycle of each ACQUIRE occupancy only.

## Test plan
- Normal bring-up (G_RST_PULSE=4, G_GOOD_CNT=8): lock rises 10 cycles after mmcm_rst_out falls, then 8 ok frames arrive → mmcm_rst_out high exactly 4 cycles, one realign pulse, link_up_out=1 after the 8th frame_evt, retry_cnt_out=0.
- Lock timeout (G_LOCK_WAIT=20, lock held low, G_MAX_RETRY=2) → three RESET_PLL pulses, then fault_out=1 with retry_cnt_out=3. clear_fault_in → retry_cnt_out=0 and state_out=1.
- Error drop (G_ERR_LIMIT=4) in LINKED: 3 bad, 1 ok, 3 bad → stays LINKED with err_cnt_out=6. One more bad → ACQUIRE, err_cnt_out=7, retry_cnt_out=1, realign pulse.
- Sync timeout (G_SYNC_TIMEOUT=50): toggles stop in LINKED → ACQUIRE 50 cycles after the last frame_evt. Continued silence re-enters ACQUIRE every 50 cycles with a fresh realign pulse each time.
- Priority: lock drop in the same cycle as a bad frame hitting G_ERR_LIMIT → RESET_PLL (not ACQUIRE), retry increments by exactly 1.
- Async reset asserted mid-RESET_PLL and mid-LINKED → outputs 0 immediately. After release, IDLE for one cycle, then RESET_PLL.
